// File: rtl/ic_period_fifo_if.sv
// Capture-side / bus-side signal bundle for ic_period_fifo.
// Optional min/max statistics signals exist only when IC_PERIOD_MINMAX_EN is defined.
interface ic_period_fifo_if #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DEPTH_LOG2 = 3
);
   logic                  i_en;
   logic                  i_ic_flg;
   logic [CNT_W-1:0]      i_cnt;
   logic                  o_clr;
   logic                  o_valid;
   logic [CNT_W-1:0]      o_data;
   logic                  i_rd;
   logic [DEPTH_LOG2:0]   o_level;
   logic                  o_ovf;
   logic                  i_ovf_clr;
`ifdef IC_PERIOD_MINMAX_EN
   logic [CNT_W-1:0]      o_min;
   logic [CNT_W-1:0]      o_max;
   logic                  i_stat_clr;

   modport slave (
      input  i_en, i_ic_flg, i_cnt, i_rd, i_ovf_clr, i_stat_clr,
      output o_clr, o_valid, o_data, o_level, o_ovf, o_min, o_max
   );
   modport master (
      output i_en, i_ic_flg, i_cnt, i_rd, i_ovf_clr, i_stat_clr,
      input  o_clr, o_valid, o_data, o_level, o_ovf, o_min, o_max
   );
`else
   modport slave (
      input  i_en, i_ic_flg, i_cnt, i_rd, i_ovf_clr,
      output o_clr, o_valid, o_data, o_level, o_ovf
   );
   modport master (
      output i_en, i_ic_flg, i_cnt, i_rd, i_ovf_clr,
      input  o_clr, o_valid, o_data, o_level, o_ovf
   );
`endif
endinterface

// File: rtl/ic_period_fifo.sv
// Period measurement from input-capture events, buffered in a FWFT FIFO.
// Define IC_PERIOD_MINMAX_EN to add running min/max period statistics.
module ic_period_fifo #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic              i_sysclk,
   input  logic              i_sysrst,
   ic_period_fifo_if.slave   bus
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic {IDLE, ARMED} state_t;

   state_t                  state;
   logic                    flg_d;
   logic                    clr;
   logic [CNT_W-1:0]        prev_cnt;
   logic [CNT_W-1:0]        mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2:0]     level;
   logic [DEPTH_LOG2:0]     level_nxt;
   logic                    ovf;

   logic                    cap_ev;
   logic                    calc;
   logic                    full;
   logic                    pop;
   logic                    wr;
   logic [CNT_W-1:0]        period;

   assign cap_ev = bus.i_ic_flg && !flg_d && bus.i_en;
   assign calc   = cap_ev && (state == ARMED);
   assign period = bus.i_cnt - prev_cnt;
   assign full   = (level == FULL_LVL);
   assign pop    = bus.i_rd && (level != '0);
   // A pop at full frees the slot the push overwrites, so the push is never lost then.
   assign wr     = calc && (!full || pop);

   always_comb begin
      level_nxt = level;
      case ({wr, pop})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
         state    <= IDLE;
         flg_d    <= 1'b0;
         clr      <= 1'b0;
         prev_cnt <= '0;
      end else begin
         flg_d <= bus.i_ic_flg;
         clr   <= cap_ev;
         if (!bus.i_en) begin
            state <= IDLE;
         end else if (cap_ev) begin
            prev_cnt <= bus.i_cnt;
            state    <= ARMED;
         end
      end
   end

   always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
         mem    <= '{default: '0};
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= period;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level <= level_nxt;
         if (calc && full && !pop) begin
            ovf <= 1'b1;
         end else if (bus.i_ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   assign bus.o_clr   = clr;
   assign bus.o_level = level;
   assign bus.o_ovf   = ovf;
   assign bus.o_valid = (level != '0);
   assign bus.o_data  = (level != '0) ? mem[rd_ptr] : '0;

`ifdef IC_PERIOD_MINMAX_EN
   logic [CNT_W-1:0] min_q;
   logic [CNT_W-1:0] max_q;

   // A period coinciding with a clear is folded into the freshly cleared values.
   always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
         min_q <= '1;
         max_q <= '0;
      end else if (bus.i_stat_clr) begin
         min_q <= calc ? period : '1;
         max_q <= calc ? period : '0;
      end else if (calc) begin
         if (period < min_q) min_q <= period;
         if (period > max_q) max_q <= period;
      end
   end

   assign bus.o_min = min_q;
   assign bus.o_max = max_q;
`endif
endmodule

// File: doc/ic_period_fifo.md
Name: ic_period_fifo

Overview:
- Downstream consumer of the 16-bit input capture stage. Takes its capture flag and captured count, and computes the period as the modulo-2^CNT_W difference between successive captures.
- Periods are buffered in a small first-word-fall-through (FWFT) FIFO for the CPU/bus side to read.
- Issues a one-cycle clear pulse back to the capture stage so that every capture event is consumed exactly once.

Parameters:
- CNT_W, 16, width of the captured count and of the stored period
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (default 8)

Ports:
- i_sysclk  in  1  system clock; all logic on the rising edge
- i_sysrst  in  1  synchronous, active-high reset
- i_en  in  1  measurement enable; when low, no captures are accepted and the armed state is cleared
- i_ic_flg  in  1  capture flag from the input capture stage (level; stays high until cleared)
- i_cnt  in  CNT_W  captured count from the input capture stage; stable while i_ic_flg is high
- o_clr  out  1  one-cycle clear pulse to the capture stage's clear input
- o_valid  out  1  FIFO not empty; o_data holds the head entry
- o_data  out  CNT_W  head period value (FWFT)
- i_rd  in  1  pop strobe; effective only when o_valid=1
- o_level  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2
- o_ovf  out  1  sticky overflow: a period was dropped because the FIFO was full
- i_ovf_clr  in  1  clears o_ovf

Behaviour:
- Reset (i_sysrst=1 at a clock edge): o_clr=0, o_valid=0, o_data=0, o_level=0, o_ovf=0. Internal state also resets: flg_d=0, armed=0, prev_cnt=0, read/write pointers=0. Reset overrides every other input. Reset mid-operation discards all stored entries.
- Edge detect: flg_d <= i_ic_flg every cycle. A capture event is i_ic_flg=1 && flg_d=0 && i_en=1 at a clock edge.
- State machine (2 states):
  - IDLE (armed=0): on a capture event, prev_cnt <= i_cnt, state -> ARMED, no FIFO push.
  - ARMED (armed=1): on a capture event, period = i_cnt - prev_cnt, truncated to CNT_W (wraps naturally); prev_cnt <= i_cnt; push the period.
  - Either state: i_en=0 -> IDLE; prev_cnt is kept but is not used.
- o_clr: registered; high for exactly one cycle after every capture event, in both states. A flag that stays high for extra cycles (clear latency) does not re-trigger, thanks to flag edge gating.
- Period of exactly 2^CNT_W ticks aliases to 0 and is stored as 0. There is no detection for this case.
- FIFO (FWFT):
  - A push is written at the capture edge; o_valid and o_data update at that same edge, so the entry is visible on the next cycle. Push-to-o_valid latency is 1 cycle from the capture edge.
  - A pop (i_rd=1 && o_valid=1) advances the head at the edge; o_data shows the next entry immediately after.
  - i_rd while empty: ignored, no underflow, state unchanged.
  - Push while full with no pop: period dropped, o_ovf <= 1, prev_cnt still updated, o_clr still pulsed.
  - Push and pop in the same cycle while full: both happen; o_level stays 2^DEPTH_LOG2; no overflow.
  - Push and pop in the same cycle while empty: the pop is ignored, the push proceeds, o_level becomes 1.
  - Push and pop in the same cycle otherwise: o_level unchanged.
- o_ovf: set has priority over i_ovf_clr in the same cycle. o_ovf is not cleared by i_en.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. o_level is an explicit counter.

Optional Feature:
- Macro: IC_PERIOD_MINMAX_EN
- Defined:
  - Adds ports o_min (out, CNT_W), o_max (out, CNT_W) and i_stat_clr (in, 1).
  - On every computed period (including dropped ones): o_min <= min(o_min, period), o_max <= max(o_max, period). Both update 1 cycle after the capture edge.
  - Reset or i_stat_clr: o_min = all ones, o_max = 0. A period arriving in the same cycle as i_stat_clr is applied to the cleared values.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset/arming: reset, i_en=1, captures with i_cnt=100 then 400 -> first capture produces no push; o_valid rises 1 cycle after the second edge with o_data=300; o_clr pulses once per capture (2 total).
- Wrap-around: prev=0xFFF0, next=0x0010 -> o_data=0x0020. Equal counts (0x1234, 0x1234) -> o_data=0.
- Overflow: 10 captures at 100-tick spacing, no reads (9 periods, depth 8) -> o_level=8, o_ovf=1; reading drains eight 100s then o_valid=0. i_ovf_clr then clears o_ovf.
- Simultaneous push/pop at full: FIFO full, i_rd=1 on the capture edge -> o_level stays 8, o_ovf stays 0, last entry holds the new period. i_rd on empty -> o_level stays 0.
- Enable/flag hold: i_ic_flg held high 5 cycles -> a single event and a single o_clr. i_en=0 between two captures, then 1 -> the next capture only re-arms, no push. Reset asserted with 3 entries stored -> o_level=0, o_valid=0 next cycle.
- IC_PERIOD_MINMAX_EN: periods 300, 50, 900 -> o_min=50, o_max=900. i_stat_clr -> 0xFFFF/0.
